// File: rtl/mult_datapath.sv
// mult_datapath: shift-and-add multiplier datapath (accumulator, multiplicand
// register and shift counter) steered by an external controller through the
// Load / Ad / Sh strobes.
// Build option: define MULT_DP_PROD_REG_EN to capture Product into a register
// on Done; otherwise Product is the low 2N accumulator bits, combinationally.
module mult_datapath #(
    parameter int N = 4
) (
    input  logic           Clk,
    input  logic           Rst_n,
    input  logic           Load,
    input  logic           Ad,
    input  logic           Sh,
    input  logic           Done,
    input  logic [N-1:0]   Mcand,
    input  logic [N-1:0]   Mplier,
    output logic           M,
    output logic           K,
    output logic [2*N-1:0] Product
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    logic [2*N:0]  acc_q, acc_d;
    logic [N-1:0]  mc_q, mc_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [N:0]    sum_s;
    logic [2*N:0]  added_s;
    logic [CW-1:0] cnt_inc_s;

    // Upper-half add (N+1 bits so the carry lands in ACC[2N]) and wrapping count.
    always_comb begin
        sum_s     = {1'b0, acc_q[2*N-1:N]} + {1'b0, mc_q};
        added_s   = {sum_s, acc_q[N-1:0]};
        if (cnt_q == CNT_LAST) begin
            cnt_inc_s = {CW{1'b0}};
        end else begin
            cnt_inc_s = cnt_q + CW'(1);
        end
    end

    // Next-state selection: Load wins; Ad+Sh together is add-then-shift in one edge.
    always_comb begin
        acc_d = acc_q;
        mc_d  = mc_q;
        cnt_d = cnt_q;
        if (Load) begin
            acc_d = {{(N+1){1'b0}}, Mplier};
            mc_d  = Mcand;
            cnt_d = {CW{1'b0}};
        end else if (Ad && Sh) begin
            acc_d = {1'b0, added_s[2*N:1]};
            cnt_d = cnt_inc_s;
        end else if (Ad) begin
            acc_d = added_s;
        end else if (Sh) begin
            acc_d = {1'b0, acc_q[2*N:1]};
            cnt_d = cnt_inc_s;
        end else begin
            acc_d = acc_q;
        end
    end

    // Datapath state registers with asynchronous clear.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            acc_q <= {(2*N+1){1'b0}};
            mc_q  <= {N{1'b0}};
            cnt_q <= {CW{1'b0}};
        end else begin
            acc_q <= acc_d;
            mc_q  <= mc_d;
            cnt_q <= cnt_d;
        end
    end

    // Controller feedback: current multiplier bit and last-shift flag.
    always_comb begin
        M = acc_q[0];
        K = (cnt_q == CNT_LAST);
    end

`ifdef MULT_DP_PROD_REG_EN
    logic [2*N-1:0] prod_q, prod_d;

    // Product capture on the completion cycle; Load does not disturb it.
    always_comb begin
        if (Done) begin
            prod_d = acc_q[2*N-1:0];
        end else begin
            prod_d = prod_q;
        end
    end

    // Product register with asynchronous clear.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            prod_q <= {(2*N){1'b0}};
        end else begin
            prod_q <= prod_d;
        end
    end

    assign Product = prod_q;
`else
    // Done only matters for the registered product build.
    logic unused_done_s;
    assign unused_done_s = Done;
    assign Product       = acc_q[2*N-1:0];
`endif

endmodule

// File: tb/tb_mult_datapath.sv
// tb_mult_datapath: directed bench for mult_datapath (N=4) with an
// arithmetic reference model and a per-cycle compare on the falling edge.
module tb_mult_datapath;

    localparam int N = 4;

    logic           Clk = 1'b0;
    logic           Rst_n = 1'b0;
    logic           Load = 1'b0;
    logic           Ad = 1'b0;
    logic           Sh = 1'b0;
    logic           Done = 1'b0;
    logic [N-1:0]   Mcand = '0;
    logic [N-1:0]   Mplier = '0;
    logic           M;
    logic           K;
    logic [2*N-1:0] Product;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: the accumulator held as a plain integer.
    int unsigned m_acc  = 0;
    int unsigned m_mc   = 0;
    int unsigned m_cnt  = 0;
    int unsigned m_prod = 0;

    mult_datapath #(.N(N)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Load(Load), .Ad(Ad), .Sh(Sh), .Done(Done),
        .Mcand(Mcand), .Mplier(Mplier), .M(M), .K(K), .Product(Product)
    );

    always #5 Clk = ~Clk;

    function automatic int unsigned next_acc(int unsigned acc, int unsigned mc,
                                             logic ld, logic ad, logic sh, int unsigned mp);
        int unsigned a;
        int unsigned hi;
        int unsigned lo;
        a = acc;
        if (ld) return mp;
        if (ad) begin
            hi = (a / (1 << N)) % (1 << N);
            lo = a % (1 << N);
            a  = (hi + mc) * (1 << N) + lo;
        end
        if (sh) a = a / 2;
        return a;
    endfunction

    // Model update on each edge; asynchronous clear mirrors the reset behaviour.
    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            m_acc  <= 0;
            m_mc   <= 0;
            m_cnt  <= 0;
            m_prod <= 0;
        end else begin
            if (Done) m_prod <= m_acc % (1 << (2*N));
            m_acc <= next_acc(m_acc, m_mc, Load, Ad, Sh, int'(Mplier));
            if (Load) begin
                m_mc  <= int'(Mcand);
                m_cnt <= 0;
            end else if (Sh) begin
                m_cnt <= (m_cnt + 1) % N;
            end
        end
    end

    function automatic int unsigned exp_product();
`ifdef MULT_DP_PROD_REG_EN
        return m_prod;
`else
        return m_acc % (1 << (2*N));
`endif
    endfunction

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Per-cycle comparison of all outputs against the model.
    always @(negedge Clk) begin
        chk("cyc_M", int'(M), m_acc % 2);
        chk("cyc_K", int'(K), (m_cnt == N-1) ? 1 : 0);
        chk("cyc_Product", int'(Product), exp_product());
    end

    task automatic cyc(input logic ld, input logic ad, input logic sh, input logic dn);
        Load = ld; Ad = ad; Sh = sh; Done = dn;
        @(posedge Clk);
        @(negedge Clk);
        Load = 1'b0; Ad = 1'b0; Sh = 1'b0; Done = 1'b0;
    endtask

    // Load, then controller-style Ad/Sh per M for N shifts, then a Done cycle.
    task automatic run_mult(input int a, input int b, input int expect_p, input string tag);
        Mcand = N'(a); Mplier = N'(b);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < N; i++) begin
            if (m_acc % 2 == 1) cyc(1'b0, 1'b1, 1'b0, 1'b0);
            if (b == 0) chk({tag, "_M0"}, int'(M), 0);
            if (i == N-1) chk({tag, "_K_last"}, int'(K), 1);
            else chk({tag, "_K_notlast"}, int'(K), 0);
            cyc(1'b0, 1'b0, 1'b1, 1'b0);
        end
        chk({tag, "_acc8"}, (m_acc >> (2*N)) % 2, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk({tag, "_product"}, int'(Product), expect_p);
    endtask

    initial begin
        @(negedge Clk);
        chk("rst_M", int'(M), 0);
        chk("rst_K", int'(K), 0);
        chk("rst_Product", int'(Product), 0);
        #2 Rst_n = 1'b1;
        @(negedge Clk);

        // Scenario 1 and 2
        run_mult(13, 11, 143, "s1");
        run_mult(15, 15, 225, "s2");

`ifdef MULT_DP_PROD_REG_EN
        // Scenario 6: product held through a new Load until the next Done
        Mcand = 4'd2; Mplier = 4'd3;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("s6_hold_load", int'(Product), 225);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("s6_hold_shift", int'(Product), 225);
        run_mult(13, 11, 143, "s6a");
        Mcand = 4'd2; Mplier = 4'd3;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("s6_hold143_load", int'(Product), 143);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("s6_hold143_step", int'(Product), 143);
        run_mult(2, 3, 6, "s6b");
`endif

        // Scenario 3: zero operands
        run_mult(9, 0, 0, "s3a");
        run_mult(0, 7, 0, "s3b");

        // Scenario 4: Load dominates Ad+Sh; combined Ad+Sh equals Ad then Sh
        Mcand = 4'd5; Mplier = 4'd3;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        Mcand = 4'd5; Mplier = 4'd6;
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        chk("s4_ld_K", int'(K), 0);
        chk("s4_ld_M", int'(M), 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("s4_ld_acc", int'(Product), 6);
        Mplier = 4'd3;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("s4_comb", int'(Product), 41);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("s4_sep", int'(Product), 41);

        // Scenario 5: off-edge reset after two shifts, then a clean 6*7
        Mcand = 4'd13; Mplier = 4'd11;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        #2 Rst_n = 1'b0;
        #1;
        chk("s5_rst_M", int'(M), 0);
        chk("s5_rst_K", int'(K), 0);
        chk("s5_rst_Product", int'(Product), 0);
        Load = 1'b1; Ad = 1'b1; Sh = 1'b1; Done = 1'b1;
        @(posedge Clk);
        #1;
        chk("s5_strobes_ignored", int'(Product), 0);
        @(negedge Clk);
        Load = 1'b0; Ad = 1'b0; Sh = 1'b0; Done = 1'b0;
        #2 Rst_n = 1'b1;
        @(negedge Clk);
        run_mult(6, 7, 42, "s5");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
